// File: rtl/wb_regfile.sv
// Write-back stage: selects the write-back value, commits it into a 2R1W integer
// register file with same-cycle WB->ID bypass, and counts retired instructions.
module wb_regfile #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 5,
  parameter int unsigned CntWidth  = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 wb_valid_i,
  input  logic                 wb_reg_w_i,
  input  logic [1:0]           wb_wb_sel_i,
  input  logic [DataWidth-1:0] wb_imm_i,
  input  logic [DataWidth-1:0] wb_pc_plus_4_i,
  input  logic [DataWidth-1:0] wb_mem_r_data_i,
  input  logic [DataWidth-1:0] wb_alu_result_i,
  input  logic [AddrWidth-1:0] wb_rd_addr_i,
  output logic [DataWidth-1:0] wb_wr_data_o,
  input  logic [AddrWidth-1:0] id_rs1_addr_i,
  input  logic [AddrWidth-1:0] id_rs2_addr_i,
  output logic [DataWidth-1:0] id_rs1_data_o,
  output logic [DataWidth-1:0] id_rs2_data_o,
  input  logic [AddrWidth-1:0] dbg_addr_i,
  output logic [DataWidth-1:0] dbg_data_o,
  output logic [CntWidth-1:0]  instret_o
);

  localparam int unsigned NumRegs = 2 ** AddrWidth;

  logic [DataWidth-1:0] regs_q [NumRegs];
  logic [CntWidth-1:0]  instret_q, instret_d;
  logic                 we;

  always_comb begin
    wb_wr_data_o = wb_alu_result_i;
    unique case (wb_wb_sel_i)
      2'b00:   wb_wr_data_o = wb_alu_result_i;
      2'b01:   wb_wr_data_o = wb_mem_r_data_i;
      2'b10:   wb_wr_data_o = wb_pc_plus_4_i;
      default: wb_wr_data_o = wb_imm_i;
    endcase
  end

  assign we = wb_valid_i & wb_reg_w_i & (wb_rd_addr_i != '0);

  // x0 is forced to zero explicitly so its read never depends on the bypass path.
  always_comb begin
    id_rs1_data_o = regs_q[id_rs1_addr_i];
    if (id_rs1_addr_i == '0) begin
      id_rs1_data_o = '0;
    end else if (we && (id_rs1_addr_i == wb_rd_addr_i)) begin
      id_rs1_data_o = wb_wr_data_o;
    end
  end

  always_comb begin
    id_rs2_data_o = regs_q[id_rs2_addr_i];
    if (id_rs2_addr_i == '0) begin
      id_rs2_data_o = '0;
    end else if (we && (id_rs2_addr_i == wb_rd_addr_i)) begin
      id_rs2_data_o = wb_wr_data_o;
    end
  end

  assign dbg_data_o = regs_q[dbg_addr_i];

  always_comb begin
    instret_d = instret_q;
    if (wb_valid_i) begin
      instret_d = instret_q + CntWidth'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      instret_q <= '0;
    end else begin
      if (we) begin
        regs_q[wb_rd_addr_i] <= wb_wr_data_o;
      end
      instret_q <= instret_d;
    end
  end

  assign instret_o = instret_q;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed, table-driven bench for wb_regfile plus hand-written reset, wrap and
// mid-write reset sequences.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid_i;
  logic        wb_reg_w_i;
  logic [1:0]  wb_wb_sel_i;
  logic [31:0] wb_imm_i;
  logic [31:0] wb_pc_plus_4_i;
  logic [31:0] wb_mem_r_data_i;
  logic [31:0] wb_alu_result_i;
  logic [4:0]  wb_rd_addr_i;
  logic [31:0] wb_wr_data_o;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic [31:0] id_rs1_data_o;
  logic [31:0] id_rs2_data_o;
  logic [4:0]  dbg_addr_i;
  logic [31:0] dbg_data_o;
  logic [63:0] instret_o;

  int unsigned passed = 0;
  int unsigned total  = 0;

  wb_regfile #(
    .DataWidth(32),
    .AddrWidth(5),
    .CntWidth (64)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .wb_valid_i     (wb_valid_i),
    .wb_reg_w_i     (wb_reg_w_i),
    .wb_wb_sel_i    (wb_wb_sel_i),
    .wb_imm_i       (wb_imm_i),
    .wb_pc_plus_4_i (wb_pc_plus_4_i),
    .wb_mem_r_data_i(wb_mem_r_data_i),
    .wb_alu_result_i(wb_alu_result_i),
    .wb_rd_addr_i   (wb_rd_addr_i),
    .wb_wr_data_o   (wb_wr_data_o),
    .id_rs1_addr_i  (id_rs1_addr_i),
    .id_rs2_addr_i  (id_rs2_addr_i),
    .id_rs1_data_o  (id_rs1_data_o),
    .id_rs2_data_o  (id_rs2_data_o),
    .dbg_addr_i     (dbg_addr_i),
    .dbg_data_o     (dbg_data_o),
    .instret_o      (instret_o)
  );

  always #5 clk = ~clk;

  // All outputs in a vector are sampled just after the negedge, i.e. before the
  // edge that commits that vector's write.
  typedef struct {
    logic        valid;
    logic        reg_w;
    logic [1:0]  sel;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  dbg;
    logic [31:0] alu;
    logic [31:0] mem;
    logic [31:0] exp_wr;
    logic [31:0] exp_rs1;
    logic [31:0] exp_rs2;
    logic [31:0] exp_dbg;
    logic [63:0] exp_instret;
  } vec_t;

  localparam int NumVecs = 13;
  vec_t vecs [NumVecs];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic drive_zero();
    wb_valid_i      = 1'b0;
    wb_reg_w_i      = 1'b0;
    wb_wb_sel_i     = 2'b00;
    wb_imm_i        = 32'h44;
    wb_pc_plus_4_i  = 32'h33;
    wb_mem_r_data_i = 32'h0;
    wb_alu_result_i = 32'h0;
    wb_rd_addr_i    = 5'd0;
    id_rs1_addr_i   = 5'd0;
    id_rs2_addr_i   = 5'd0;
    dbg_addr_i      = 5'd0;
  endtask

  initial begin
    //          vld   rw    sel    rd     rs1    rs2    dbg    alu           mem
    //          wr            rs1           rs2           dbg           instret
    vecs[0]  = '{1'b1, 1'b1, 2'd0, 5'd5,  5'd5,  5'd0,  5'd5,  32'h11,       32'h22,
                 32'h11,       32'h11,       32'h0,        32'h0,        64'd0};
    vecs[1]  = '{1'b1, 1'b1, 2'd1, 5'd5,  5'd6,  5'd5,  5'd5,  32'h11,       32'h22,
                 32'h22,       32'h0,        32'h22,       32'h11,       64'd1};
    vecs[2]  = '{1'b1, 1'b1, 2'd2, 5'd5,  5'd5,  5'd5,  5'd5,  32'h11,       32'h22,
                 32'h33,       32'h33,       32'h33,       32'h22,       64'd2};
    vecs[3]  = '{1'b1, 1'b1, 2'd3, 5'd5,  5'd0,  5'd0,  5'd5,  32'h11,       32'h22,
                 32'h44,       32'h0,        32'h0,        32'h33,       64'd3};
    vecs[4]  = '{1'b1, 1'b1, 2'd0, 5'd0,  5'd0,  5'd5,  5'd5,  32'hDEADBEEF, 32'h22,
                 32'hDEADBEEF, 32'h0,        32'h44,       32'h44,       64'd4};
    vecs[5]  = '{1'b0, 1'b1, 2'd0, 5'd9,  5'd9,  5'd0,  5'd0,  32'h99,       32'h22,
                 32'h99,       32'h0,        32'h0,        32'h0,        64'd5};
    vecs[6]  = '{1'b1, 1'b1, 2'd0, 5'd7,  5'd7,  5'd7,  5'd9,  32'hCAFE,     32'h22,
                 32'hCAFE,     32'hCAFE,     32'hCAFE,     32'h0,        64'd5};
    vecs[7]  = '{1'b1, 1'b0, 2'd1, 5'd8,  5'd8,  5'd7,  5'd7,  32'h0,        32'h88,
                 32'h88,       32'h0,        32'hCAFE,     32'hCAFE,     64'd6};
    vecs[8]  = '{1'b1, 1'b1, 2'd0, 5'd10, 5'd10, 5'd8,  5'd8,  32'hA1,       32'h0,
                 32'hA1,       32'hA1,       32'h0,        32'h0,        64'd7};
    vecs[9]  = '{1'b1, 1'b1, 2'd0, 5'd10, 5'd11, 5'd10, 5'd10, 32'hA2,       32'h0,
                 32'hA2,       32'h0,        32'hA2,       32'hA1,       64'd8};
    vecs[10] = '{1'b0, 1'b0, 2'd3, 5'd10, 5'd10, 5'd5,  5'd10, 32'h0,        32'h0,
                 32'h44,       32'hA2,       32'h44,       32'hA2,       64'd9};
    vecs[11] = '{1'b0, 1'b0, 2'd0, 5'd0,  5'd0,  5'd7,  5'd5,  32'h0,        32'h0,
                 32'h0,        32'h0,        32'hCAFE,     32'h44,       64'd9};
    vecs[12] = '{1'b0, 1'b0, 2'd0, 5'd0,  5'd8,  5'd0,  5'd0,  32'h0,        32'h0,
                 32'h0,        32'h0,        32'h0,        32'h0,        64'd9};

    // Reset with random inputs; bypass stays live while rst is high.
    rst             = 1'b1;
    wb_valid_i      = 1'b1;
    wb_reg_w_i      = 1'b1;
    wb_wb_sel_i     = 2'b00;
    wb_imm_i        = $urandom;
    wb_pc_plus_4_i  = $urandom;
    wb_mem_r_data_i = $urandom;
    wb_alu_result_i = $urandom;
    wb_rd_addr_i    = 5'd3;
    id_rs1_addr_i   = 5'd3;
    id_rs2_addr_i   = 5'd4;
    dbg_addr_i      = 5'd3;
    #1;
    check("rst_rs1_bypass", {32'h0, id_rs1_data_o}, {32'h0, wb_alu_result_i});
    check("rst_rs2_zero", {32'h0, id_rs2_data_o}, 64'h0);
    @(posedge clk);
    #1;
    check("rst_dbg_x3", {32'h0, dbg_data_o}, 64'h0);
    check("rst_instret", instret_o, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    drive_zero();
    for (int r = 1; r < 32; r++) begin
      dbg_addr_i = 5'(r);
      #0.1;
      check($sformatf("reset_dbg_x%0d", r), {32'h0, dbg_data_o}, 64'h0);
    end
    check("reset_instret", instret_o, 64'h0);

    for (int v = 0; v < NumVecs; v++) begin
      @(negedge clk);
      wb_valid_i      = vecs[v].valid;
      wb_reg_w_i      = vecs[v].reg_w;
      wb_wb_sel_i     = vecs[v].sel;
      wb_rd_addr_i    = vecs[v].rd;
      id_rs1_addr_i   = vecs[v].rs1;
      id_rs2_addr_i   = vecs[v].rs2;
      dbg_addr_i      = vecs[v].dbg;
      wb_alu_result_i = vecs[v].alu;
      wb_mem_r_data_i = vecs[v].mem;
      #1;
      check($sformatf("v%0d_wr_data", v), {32'h0, wb_wr_data_o}, {32'h0, vecs[v].exp_wr});
      check($sformatf("v%0d_rs1", v), {32'h0, id_rs1_data_o}, {32'h0, vecs[v].exp_rs1});
      check($sformatf("v%0d_rs2", v), {32'h0, id_rs2_data_o}, {32'h0, vecs[v].exp_rs2});
      check($sformatf("v%0d_dbg", v), {32'h0, dbg_data_o}, {32'h0, vecs[v].exp_dbg});
      check($sformatf("v%0d_instret", v), instret_o, vecs[v].exp_instret);
    end

    // Counter wrap from all-ones.
    @(negedge clk);
    drive_zero();
    force dut.instret_q = {64{1'b1}};
    #1;
    release dut.instret_q;
    #1;
    check("wrap_preload", instret_o, {64{1'b1}});
    wb_valid_i = 1'b1;
    @(posedge clk);
    #1;
    check("wrap_to_zero", instret_o, 64'h0);

    // Build some state, then reset in the middle of a pending write.
    @(negedge clk);
    wb_valid_i      = 1'b1;
    wb_reg_w_i      = 1'b1;
    wb_rd_addr_i    = 5'd12;
    wb_alu_result_i = 32'h55;
    @(negedge clk);
    wb_rd_addr_i    = 5'd13;
    wb_alu_result_i = 32'h77;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    dbg_addr_i = 5'd12;
    #0.1;
    check("midrst_dbg_x12", {32'h0, dbg_data_o}, 64'h0);
    dbg_addr_i = 5'd13;
    #0.1;
    check("midrst_dbg_x13", {32'h0, dbg_data_o}, 64'h0);
    dbg_addr_i = 5'd7;
    #0.1;
    check("midrst_dbg_x7", {32'h0, dbg_data_o}, 64'h0);
    check("midrst_instret", instret_o, 64'h0);

    // First write is accepted at the first edge after release.
    @(negedge clk);
    rst             = 1'b0;
    wb_rd_addr_i    = 5'd12;
    wb_alu_result_i = 32'h66;
    dbg_addr_i      = 5'd12;
    @(posedge clk);
    #1;
    check("post_rst_write", {32'h0, dbg_data_o}, 64'h66);
    check("post_rst_instret", instret_o, 64'd1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
